// File: rtl/sram_axi_bridge.sv
// SRAM-style core ports to a single-beat AXI master, one transaction outstanding at a time.
// Optional macro BRIDGE_WBUF_EN: stores retire on AW+W and the B response is tracked in the background.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  // state | meaning
  // IDLE  | no transaction; a request is captured and stall raised in the same cycle
  // D_RD  | load: AR id=1, wait for R id=1
  // D_WR  | store: AW and W independently, then B (or buffered B)
  // I_RD  | fetch: AR id=0, wait for R id=0
  // DONE  | one unstalled cycle so the core consumes the held rdata
  typedef enum logic [2:0] {IDLE, D_RD, D_WR, I_RD, DONE} state_t;

  state_t      state_q, state_d;
  logic        fetch_q, fetch_d;
  logic [31:0] iaddr_q, iaddr_d, daddr_q, daddr_d, dwdata_q, dwdata_d;
  logic [3:0]  dwen_q, dwen_d;
  logic [31:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic        ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        req, ar_hs, aw_hs, w_hs, aw_fin, w_fin, wr_fin, r_hit_d, r_hit_i;
  logic        b_block;

  assign req    = inst_sram_en | data_sram_en;
  assign ar_hs  = arvalid & arready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  // R is only accepted after our own AR went out, so stale beats cannot complete a read
  assign r_hit_d = (state_q == D_RD) & rvalid & ar_done_q & (rid == 4'd1);
  assign r_hit_i = (state_q == I_RD) & rvalid & ar_done_q & (rid == 4'd0);

`ifdef BRIDGE_WBUF_EN
  logic bpend_q, bpend_d;

  assign wr_fin  = aw_fin & w_fin;
  assign b_block = bpend_q;

  always_comb begin
    bpend_d = bpend_q;
    if (bvalid & bready) bpend_d = 1'b0;
    if ((state_q == D_WR) & wr_fin & ~bvalid) bpend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bpend_q <= 1'b0;
    else      bpend_q <= bpend_d;
  end
`else
  assign wr_fin  = aw_fin & w_fin & bvalid;
  assign b_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fetch_q   <= 1'b0;
      iaddr_q   <= 32'h0;
      daddr_q   <= 32'h0;
      dwdata_q  <= 32'h0;
      dwen_q    <= 4'h0;
      irdata_q  <= 32'h0;
      drdata_q  <= 32'h0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      iaddr_q   <= iaddr_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      dwen_q    <= dwen_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_sram_en)      state_d = (data_sram_wen != 4'd0) ? D_WR : D_RD;
        else if (inst_sram_en) state_d = I_RD;
      end
      D_RD:    if (r_hit_d) state_d = fetch_q ? I_RD : DONE;
      D_WR:    if (wr_fin)  state_d = fetch_q ? I_RD : DONE;
      I_RD:    if (r_hit_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_d  = fetch_q;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dwen_d   = dwen_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    if ((state_q == IDLE) & req) begin
      fetch_d  = inst_sram_en;
      iaddr_d  = inst_sram_addr;
      daddr_d  = data_sram_addr;
      dwdata_d = data_sram_wdata;
      dwen_d   = data_sram_wen;
    end
    if (r_hit_d) drdata_d = rdata;
    if (r_hit_i) irdata_d = rdata;
    // per-phase handshake tracking restarts on every state change
    ar_done_d = ar_done_q | ar_hs;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
    if (state_d != state_q) begin
      ar_done_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_comb begin
    stallreq = 1'b0;
    arid     = 4'd0;
    araddr   = 32'h0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awaddr   = 32'h0;
    awvalid  = 1'b0;
    wdata    = 32'h0;
    wstrb    = 4'h0;
    wvalid   = 1'b0;
    bready   = b_block;
    case (state_q)
      IDLE: stallreq = req;
      D_RD: begin
        stallreq = 1'b1;
        arid     = 4'd1;
        araddr   = daddr_q;
        arvalid  = ~ar_done_q & ~b_block;
        rready   = 1'b1;
      end
      I_RD: begin
        stallreq = 1'b1;
        araddr   = iaddr_q;
        arvalid  = ~ar_done_q & ~b_block;
        rready   = 1'b1;
      end
      D_WR: begin
        stallreq = 1'b1;
        awaddr   = daddr_q;
        wdata    = dwdata_q;
        wstrb    = dwen_q;
        awvalid  = ~aw_done_q & ~b_block;
        wvalid   = ~w_done_q & ~b_block;
        bready   = 1'b1;
      end
      default: ;
    endcase
    if (!rst) stallreq = 1'b0;
  end

  assign arsize          = 3'd2;
  assign awsize          = 3'd2;
  assign inst_sram_rdata = irdata_q;
  assign data_sram_rdata = drdata_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: acts as core and AXI slave, checks against a transaction-level memory model.
module tb_sram_axi_bridge;
`ifdef BRIDGE_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic inst_sram_en, data_sram_en;
  logic [31:0] inst_sram_addr, inst_sram_rdata, data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] data_sram_wen;
  logic stallreq;
  logic [3:0] arid, rid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int pass_n = 0, chk_n = 0;
  int cyc = 0;
  // slave and transaction model state
  int ar_lat, r_lat, aw_lat, w_lat, b_lat, ar_cnt, aw_cnt, w_cnt;
  int r_due, stray_due, b_due, r_acc_cyc, b_hs_cyc, last_wh_cyc, stall_n;
  logic [3:0] r_id_m;
  logic [31:0] r_data_m;
  bit stray_en, aw_m, w_m, b_started, b_pend, stall_s;
  bit overlap_f, drop_f, bblk_f;
  bit cur_fetch, cur_load, cur_store;
  logic [31:0] cur_iaddr, cur_daddr, cur_wdata, exp_i, exp_d;
  logic [3:0] cur_wen;
  int ar_id_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C01_0001;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    r_due = -1; stray_due = -1; b_due = -1; b_pend = 0; b_started = 0;
    aw_m = 0; w_m = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    exp_i = 32'h0; exp_d = 32'h0; cur_store = 0; cur_load = 0; cur_fetch = 0;
    arready = 0; rvalid = 0; rid = 4'hF; rdata = 32'h0; awready = 0; wready = 0; bvalid = 0;
  endtask

  // second half of a cycle: slave responds from the DUT's registered outputs, then handshakes are scored
  task automatic cyc_end();
    bit will_aw, will_w;
    logic [31:0] exp_a;
    arready = arvalid && (ar_cnt >= ar_lat);
    awready = awvalid && (aw_cnt >= aw_lat);
    wready  = wvalid && (w_cnt >= w_lat);
    will_aw = aw_m || (awvalid && awready);
    will_w  = w_m || (wvalid && wready);
    if (cur_store && !b_started && will_aw && will_w) begin
      b_started = 1; b_pend = 1; b_due = cyc + b_lat; last_wh_cyc = cyc;
    end
    bvalid = b_pend && (cyc >= b_due);
    if (r_due >= 0 && cyc >= r_due) begin
      rvalid = 1; rid = r_id_m; rdata = r_data_m;
    end else if (stray_due == cyc) begin
      rvalid = 1; rid = 4'd2; rdata = 32'hDEAD_BEEF;
    end else begin
      rvalid = 0; rid = 4'hF; rdata = 32'h0;
    end
    #1;
    stall_s = stallreq;
    if (stallreq) stall_n++;
    if (arvalid && awvalid) overlap_f = 1;
    if (arvalid && b_pend) bblk_f = 1;
    if ((awvalid || wvalid) && b_pend && !b_started) bblk_f = 1;
    if (awvalid && aw_m) drop_f = 1;
    if (wvalid && w_m) drop_f = 1;
    if (arvalid && arready) begin
      ar_id_q.push_back(int'(arid));
      exp_a = (arid == 4'd1) ? cur_daddr : cur_iaddr;
      chk("araddr", araddr, exp_a);
      chk("arsize", 32'(arsize), 32'd2);
      r_due = cyc + r_lat; r_id_m = arid; r_data_m = mem_word(exp_a); ar_cnt = 0;
      if (stray_en && arid == 4'd0) stray_due = cyc + 1;
    end else if (arvalid) ar_cnt++;
    if (rvalid && rready && r_due >= 0 && cyc >= r_due) begin
      r_acc_cyc = cyc; r_due = -1;
    end
    if (awvalid && awready) begin
      chk("awaddr", awaddr, cur_daddr);
      chk("awsize", 32'(awsize), 32'd2);
      aw_m = 1; aw_cnt = 0;
    end else if (awvalid) aw_cnt++;
    if (wvalid && wready) begin
      chk("wdata", wdata, cur_wdata);
      chk("wstrb", 32'(wstrb), 32'(cur_wen));
      w_m = 1; w_cnt = 0;
    end else if (wvalid) w_cnt++;
    if (bvalid && bready) begin
      b_pend = 0; b_hs_cyc = cyc; b_due = -1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inst_sram_en = 0; data_sram_en = 0;
      cyc_end();
    end
  endtask

  task automatic run_txn(input bit f, input bit ld, input bit st, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wn,
                         input int arl, input int rl, input int awl, input int wl, input int bl,
                         input bit stray);
    int start, done_c, last_ev, n_exp;
    int exp_ids[$];
    bit to;
    cur_fetch = f; cur_load = ld; cur_store = st;
    cur_iaddr = ia; cur_daddr = da; cur_wdata = wd; cur_wen = wn;
    ar_lat = arl; r_lat = rl; aw_lat = awl; w_lat = wl; b_lat = bl;
    stray_en = stray; stray_due = -1;
    aw_m = 0; w_m = 0; b_started = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    ar_id_q.delete(); overlap_f = 0; drop_f = 0; bblk_f = 0; stall_n = 0;
    r_acc_cyc = -1; b_hs_cyc = -1; last_wh_cyc = -1;
    start = cyc; to = 1; done_c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) begin
        inst_sram_en = f; inst_sram_addr = ia;
        data_sram_en = ld || st; data_sram_wen = st ? wn : 4'd0;
        data_sram_addr = da; data_sram_wdata = wd;
      end else begin
        inst_sram_en = 1'($urandom); inst_sram_addr = $urandom;
        data_sram_en = 1'($urandom); data_sram_wen = 4'($urandom);
        data_sram_addr = $urandom; data_sram_wdata = $urandom;
      end
      cyc_end();
      if (!stall_s) begin
        done_c = cyc - 1; to = 0;
        break;
      end
    end
    chk("txn_timeout", 32'(to), 32'd0);
    if (to) return;
    if (ld) exp_ids.push_back(1);
    if (f) exp_ids.push_back(0);
    n_exp = exp_ids.size();
    chk("ar_count", 32'(ar_id_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < ar_id_q.size(); i++)
      chk("ar_order", 32'(ar_id_q[i]), 32'(exp_ids[i]));
    if (ld) exp_d = mem_word(da);
    if (f) exp_i = mem_word(ia);
    chk("data_rdata", data_sram_rdata, exp_d);
    chk("inst_rdata", inst_sram_rdata, exp_i);
    if (ld || f) last_ev = r_acc_cyc;
    else last_ev = WBUF ? last_wh_cyc : b_hs_cyc;
    chk("exit_cycle", 32'(done_c), 32'(last_ev + 1));
    if (st) begin
      chk("aw_handshake", 32'(aw_m), 32'd1);
      chk("w_handshake", 32'(w_m), 32'd1);
    end
    chk("ar_aw_overlap", 32'(overlap_f), 32'd0);
    chk("valid_after_handshake", 32'(drop_f), 32'd0);
    chk("issue_while_b_pending", 32'(bblk_f), 32'd0);
  endtask

  task automatic rand_txns(input int n);
    int kind, rl;
    bit f, ld, st, stray;
    logic [31:0] ia, da;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 4);
      f  = (kind == 0) || (kind == 3) || (kind == 4);
      ld = (kind == 1) || (kind == 3);
      st = (kind == 2) || (kind == 4);
      stray = f && ($urandom_range(0, 2) == 0);
      rl = stray ? $urandom_range(2, 4) : $urandom_range(1, 4);
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom & 32'hFFFF_FFFC;
      run_txn(f, ld, st, ia, da, $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 3), rl, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 4), stray);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 0;
    inst_sram_en = 1; data_sram_en = 1; data_sram_wen = 4'h0;
    inst_sram_addr = 32'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    #12;
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", data_sram_rdata, 32'h0);
    @(negedge clk);
    rst = 1; inst_sram_en = 0; data_sram_en = 0;
    idle(2);

    // fetch only, R two cycles after the AR handshake
    run_txn(1, 0, 0, 32'hBFC0_0000, 32'h0, 32'h0, 4'h0, 0, 2, 0, 0, 0, 0);
    chk("fetch_stall_cycles", 32'(stall_n), 32'd4);
    chk("fetch_rdata_const", inst_sram_rdata, 32'h3C01_0001);
    // load plus fetch
    run_txn(1, 1, 0, 32'hBFC0_0004, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0);
    // store, W three cycles after AW
    run_txn(0, 0, 1, 32'h0, 32'h8000_0020, 32'h1234_ABCD, 4'b0011, 0, 1, 0, 3, 2, 0);
    // store, AW late; B in the same cycle as the last handshake
    run_txn(0, 0, 1, 32'h0, 32'h8000_0024, 32'hCAFE_0001, 4'b1000, 0, 1, 3, 0, 0, 0);
    // fetch with a foreign-id beat ahead of the real one
    run_txn(1, 0, 0, 32'hBFC0_0100, 32'h0, 32'h0, 4'h0, 0, 3, 0, 0, 0, 1);
    // store with slow B immediately followed by a load
    run_txn(0, 0, 1, 32'h0, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 1, 0, 1, 5, 0);
    run_txn(0, 1, 0, 32'h0, 32'h8000_0044, 32'h0, 4'h0, 0, 1, 0, 0, 0, 0);
    // store plus fetch
    run_txn(1, 0, 1, 32'hBFC0_0200, 32'h8000_0048, 32'h5555_AAAA, 4'b0110, 0, 2, 1, 1, 3, 0);

    rand_txns(24);
    idle(8);

    // reset while a load waits for arready
    cur_load = 1; cur_fetch = 0; cur_store = 0; cur_daddr = 32'h8000_0080;
    ar_lat = 1000; stray_en = 0; r_due = -1; stray_due = -1;
    @(negedge clk);
    data_sram_en = 1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0080;
    cyc_end();
    @(negedge clk);
    data_sram_en = 0;
    cyc_end();
    chk("pre_rst_arvalid", 32'(arvalid), 32'd1);
    @(negedge clk);
    rst = 0; inst_sram_en = 1; data_sram_en = 1;
    #1;
    chk("mid_rst_stallreq", 32'(stallreq), 32'd0);
    chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
    chk("mid_rst_awvalid", 32'(awvalid), 32'd0);
    chk("mid_rst_wvalid", 32'(wvalid), 32'd0);
    chk("mid_rst_rready", 32'(rready), 32'd0);
    chk("mid_rst_bready", 32'(bready), 32'd0);
    chk("mid_rst_araddr", araddr, 32'h0);
    chk("mid_rst_arid", 32'(arid), 32'd0);
    chk("mid_rst_data_rdata", data_sram_rdata, 32'h0);
    chk("mid_rst_inst_rdata", inst_sram_rdata, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    inst_sram_en = 0; data_sram_en = 0; rst = 1;
    // late response for the abandoned load must be ignored in IDLE
    @(negedge clk);
    rvalid = 1; rid = 4'd1; rdata = 32'h1111_2222; bvalid = 1;
    #1;
    chk("late_r_stallreq", 32'(stallreq), 32'd0);
    @(negedge clk);
    rvalid = 0; bvalid = 0;
    #1;
    chk("late_r_data_rdata", data_sram_rdata, 32'h0);
    chk("late_r_inst_rdata", inst_sram_rdata, 32'h0);
    run_txn(1, 0, 0, 32'hBFC0_0300, 32'h0, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
